id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised decode stage for the 5-stage pipeline. It contains the register file, with WB-to-ID write-through bypass, and the immediate/field decode. It adds load-use hazard detection and a registered ID/EX output with a valid/ready handshake and flush. It sits between IF/ID and EX and replaces the purely combinational decode for multi-cycle-capable EX and for wider datapaths.

Parameters:
XLEN, 32, datapath/register width in bits; must be ≥ 32.
REG_ADDR_W, 5, register index width; the register file has 2**REG_ADDR_W entries. Instruction fields rs/rt/rd use the low REG_ADDR_W bits of their 5-bit fields.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  if_instr holds a valid instruction
if_instr  in  32  instruction from IF/ID
id_ready  out  1  ID accepts if_instr this cycle
flush  in  1  kill ID/EX contents (branch/exception)
wb_reg_write  in  1  WB write enable
wb_rd  in  REG_ADDR_W  WB destination
wb_wd  in  XLEN  WB write data
ex_ready  in  1  EX accepts the ID/EX payload
ex_valid  out  1  ID/EX payload valid
ex_opcode  out  6  instr[31:26]
ex_rs, ex_rt, ex_rd  out  REG_ADDR_W each  register indices
ex_shamt  out  5  instr[10:6]
ex_rs_val, ex_rt_val  out  XLEN each  operand values
ex_imm  out  XLEN  extended immediate
stall_cycles  out  32  load-use stall count (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): ex_valid=0; all ex_* payload outputs=0; all register file entries=0; stall_cycles=0.
- Register file:
  - Write on rising clk when wb_reg_write=1 and wb_rd≠0.
  - Entry 0 always reads 0.
  - Reads are combinational with write-through: if wb_reg_write=1, wb_rd≠0 and wb_rd equals the read index, the read returns wb_wd in the same cycle.
- Immediate, by opcode:
  - 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend instr[15:0] to XLEN.
  - 0x0F (lui): {instr[15:0],16'b0}, then sign-extended from bit 31 to XLEN.
  - All other opcodes: sign-extend instr[15:0].
- Load-use hazard, combinational:
  - hazard = if_valid & ex_valid & (ex_opcode==0x23) & (ex_rt≠0) & (ex_rt==rs | ex_rt==rt), where rs/rt are the decoded fields of if_instr.
  - rt is compared for every opcode (conservative).
- Handshake:
  - id_ready = ~flush & ~hazard & (~ex_valid | ex_ready).
  - A transfer occurs when if_valid & id_ready. The upstream source must hold if_instr until it transfers.
- ID/EX register update, on rising clk, in priority order:
  1. flush=1: ex_valid←0; payload don't-care.
  2. ex_valid=1 & ex_ready=0: hold everything. The payload must stay bit-stable.
  3. Otherwise: ex_valid←(if_valid & ~hazard). The payload loads only when that term is 1.
  - Consequence: hazard with EX draining inserts exactly one bubble (ex_valid=0). The stall lasts one cycle after the load leaves ID/EX.
- Latency: one cycle from transfer to ex_valid=1. Full throughput of 1 instruction/cycle when ex_ready=1 and there is no hazard.
- Operand values are captured at transfer. Later WB writes do not update a held payload; EX forwarding covers that.
- Simultaneous cases:
  - WB write to a register read in the transferring instruction: the captured value is wb_wd.
  - flush together with hazard: flush wins, ex_valid←0, and hazard clears next cycle.
- Reset asserted mid-operation: state clears immediately. After rst_n rises, the first valid instruction transfers with id_ready=1.

Optional Feature:
PERF_CNT_EN:
- Defined: stall_cycles increments by 1 on each rising clk where if_valid & hazard & ~flush. It saturates at 0xFFFF_FFFF and is cleared only by reset.
- Undefined: no counter logic; stall_cycles is tied to 0.

Test Plan:
- Reset, then a write-through read: write wb_rd=3, wb_wd=0xDEADBEEF while if_instr=addi $4,$3,-1 transfers → next cycle ex_rs_val=0xDEADBEEF, ex_imm=0xFFFF_FFFF (XLEN=32); a write to wb_rd=0 leaves reg 0 reading 0.
- Immediate decode: ori imm 0x8001 → ex_imm=0x0000_8001; lui imm 0x8001 → 0x8001_0000 (XLEN=64: 0xFFFF_FFFF_8001_0000); lw imm 0x8001 → 0xFFFF_8001.
- Load-use: lw $5,0($1) is in ID/EX with ex_ready=1, followed by add $6,$5,$2 → id_ready=0 for 1 cycle, ex_valid=0 for 1 cycle, the add transfers the next cycle; with PERF_CNT_EN, stall_cycles=1.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 → all payload outputs stable, id_ready=0; ex_ready→1 → the next instruction loads the following cycle.
- Flush: flush=1 while ex_valid=1 and if_valid=1 → the following cycle ex_valid=0 and the instruction is not consumed (id_ready was 0).
- Async reset mid-stream: drop rst_n between clock edges → ex_valid=0 immediately; register 3 (previously 0xDEADBEEF) reads 0 after release.

Source files
------------

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage: register file, immediate decode, load-use stall, registered ID/EX
// Optional feature macro: PERF_CNT_EN (load-use stall cycle counter on stall_cycles).
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    output logic                  id_ready,
    input  logic                  flush,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_wd,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [5:0]            ex_opcode,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [4:0]            ex_shamt,
    output logic [XLEN-1:0]       ex_rs_val,
    output logic [XLEN-1:0]       ex_rt_val,
    output logic [XLEN-1:0]       ex_imm,
    output logic [31:0]           stall_cycles
);

    localparam int NREGS = 2 ** REG_ADDR_W;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;

    logic [XLEN-1:0]       regs [NREGS];
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [4:0]            shamt;
    logic [XLEN-1:0]       rs_val, rt_val, imm;
    logic                  hazard;
    logic                  hold;
    logic                  load;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[21 +: REG_ADDR_W];
    assign rt     = if_instr[16 +: REG_ADDR_W];
    assign rd     = if_instr[11 +: REG_ADDR_W];
    assign shamt  = if_instr[10:6];

    // Write-through: a same-cycle WB write is visible to the instruction being decoded.
    always_comb begin
        rs_val = regs[rs];
        if (rs == '0)
            rs_val = '0;
        else if (wb_reg_write && wb_rd == rs)
            rs_val = wb_wd;
    end

    always_comb begin
        rt_val = regs[rt];
        if (rt == '0)
            rt_val = '0;
        else if (wb_reg_write && wb_rd == rt)
            rt_val = wb_wd;
    end

    always_comb begin
        imm = {XLEN{if_instr[15]}};
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: begin
                imm       = '0;
                imm[15:0] = if_instr[15:0];
            end
            OP_LUI: begin
                imm       = {XLEN{if_instr[15]}};
                imm[31:0] = {if_instr[15:0], 16'h0000};
            end
            default: imm[15:0] = if_instr[15:0];
        endcase
    end

    // rt is compared even for opcodes that do not read it; a spare stall is harmless.
    assign hazard = if_valid && ex_valid && (ex_opcode == OP_LW) && (ex_rt != '0) &&
                    ((ex_rt == rs) || (ex_rt == rt));

    assign hold     = ex_valid && !ex_ready;
    assign id_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign load     = if_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_reg_write && wb_rd != '0) begin
            regs[wb_rd] <= wb_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_shamt  <= '0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!hold) begin
            ex_valid <= if_valid && !hazard;
            if (load) begin
                ex_opcode <= opcode;
                ex_rs     <= rs;
                ex_rt     <= rt;
                ex_rd     <= rd;
                ex_shamt  <= shamt;
                ex_rs_val <= rs_val;
                ex_rt_val <= rt_val;
                ex_imm    <= imm;
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (if_valid && hazard && !flush && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
